// File: rtl/status_request_queue.sv
// Request FIFO in front of the status register file: accepts tagged read/write
// requests over valid/ready and presents the head entry until the downstream stage consumes it.
module status_request_queue #(
  parameter int WORD_WIDTH = 12,
  parameter int ADDR_WIDTH = 3,
  parameter int TAG_WIDTH  = 1,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  i_req_valid,
  input  logic                  i_req_wen,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [WORD_WIDTH-1:0] i_req_data,
  output logic                  o_req_ready,
  output logic [TAG_WIDTH-1:0]  o_req_tag,
  input  logic                  i_flush,
  input  logic                  i_freeze,
  output logic [TAG_WIDTH-1:0]  o_tag,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [WORD_WIDTH-1:0] o_data,
  output logic                  o_wen,
  output logic                  o_valid,
  output logic [DEPTH_LOG2:0]   o_count
);

  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam int ENTRY_W = TAG_WIDTH + 1 + ADDR_WIDTH + WORD_WIDTH;

  localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   COUNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);
  localparam logic [TAG_WIDTH-1:0]  TAG_ONE    = TAG_WIDTH'(1);

  logic [ENTRY_W-1:0]    r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wrPtr;
  logic [DEPTH_LOG2-1:0] r_rdPtr;
  logic [DEPTH_LOG2:0]   r_count;
  logic [TAG_WIDTH-1:0]  r_tagCnt;

  logic w_push;
  logic w_pop;

  // Ready ignores a same-cycle pop, so a full queue refuses even while draining.
  assign o_req_ready = (r_count != FULL_COUNT) & ~i_flush;
  assign o_req_tag   = r_tagCnt;
  assign o_valid     = (r_count != '0);
  assign o_count     = r_count;

  assign w_push = i_req_valid & o_req_ready;
  assign w_pop  = o_valid & ~i_freeze & ~i_flush;

  // Head is read straight out of storage; freeze holds it because the read pointer stops.
  assign {o_tag, o_wen, o_addr, o_data} = r_mem[r_rdPtr];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_wrPtr  <= '0;
      r_rdPtr  <= '0;
      r_count  <= '0;
      r_tagCnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      // Flush empties the queue but keeps the tag sequence running.
      r_count <= '0;
      r_rdPtr <= r_wrPtr;
    end else begin
      if (w_push) begin
        r_mem[r_wrPtr] <= {r_tagCnt, i_req_wen, i_req_addr, i_req_data};
        r_wrPtr        <= r_wrPtr + PTR_ONE;
        r_tagCnt       <= r_tagCnt + TAG_ONE;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + COUNT_ONE;
        2'b01:   r_count <= r_count - COUNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_status_request_queue.sv
// Scoreboard bench for status_request_queue: a reference queue tracks accepted
// requests and every cycle compares handshake, occupancy and head fields against it.
module tb_status_request_queue;

  typedef struct packed {
    logic [0:0]  tag;
    logic        wen;
    logic [2:0]  addr;
    logic [11:0] data;
  } entry_t;

  logic        clk;
  logic        arst_n;
  logic        i_req_valid;
  logic        i_req_wen;
  logic [2:0]  i_req_addr;
  logic [11:0] i_req_data;
  logic        o_req_ready;
  logic [0:0]  o_req_tag;
  logic        i_flush;
  logic        i_freeze;
  logic [0:0]  o_tag;
  logic [2:0]  o_addr;
  logic [11:0] o_data;
  logic        o_wen;
  logic        o_valid;
  logic [2:0]  o_count;

  entry_t     sbq[$];
  logic [0:0] modelTag;
  int         testCount;
  int         failCount;

  status_request_queue #(
    .WORD_WIDTH(12),
    .ADDR_WIDTH(3),
    .TAG_WIDTH(1),
    .DEPTH_LOG2(2)
  ) dut (
    .clk(clk),
    .arst_n(arst_n),
    .i_req_valid(i_req_valid),
    .i_req_wen(i_req_wen),
    .i_req_addr(i_req_addr),
    .i_req_data(i_req_data),
    .o_req_ready(o_req_ready),
    .o_req_tag(o_req_tag),
    .i_flush(i_flush),
    .i_freeze(i_freeze),
    .o_tag(o_tag),
    .o_addr(o_addr),
    .o_data(o_data),
    .o_wen(o_wen),
    .o_valid(o_valid),
    .o_count(o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare pre-edge outputs to the model, advance the model across the edge.
  task automatic applyStimulus(input logic valid, input logic wen, input logic [2:0] addr,
                               input logic [11:0] data, input logic freeze, input logic flush);
    logic expReady;
    logic push;
    logic pop;
    i_req_valid = valid;
    i_req_wen   = wen;
    i_req_addr  = addr;
    i_req_data  = data;
    i_freeze    = freeze;
    i_flush     = flush;
    #1;
    expReady = (sbq.size() != 4) && !flush;
    checkOutput("ready", 32'(o_req_ready), 32'(expReady));
    checkOutput("reqTag", 32'(o_req_tag), 32'(modelTag));
    checkOutput("count", 32'(o_count), 32'(sbq.size()));
    checkOutput("valid", 32'(o_valid), 32'(sbq.size() != 0));
    if (sbq.size() != 0) begin
      checkOutput("headTag", 32'(o_tag), 32'(sbq[0].tag));
      checkOutput("headWen", 32'(o_wen), 32'(sbq[0].wen));
      checkOutput("headAddr", 32'(o_addr), 32'(sbq[0].addr));
      checkOutput("headData", 32'(o_data), 32'(sbq[0].data));
    end
    push = valid && expReady;
    pop  = (sbq.size() != 0) && !freeze && !flush;
    if (flush) begin
      sbq.delete();
    end else begin
      if (pop) void'(sbq.pop_front());
      if (push) begin
        sbq.push_back('{tag: modelTag, wen: wen, addr: addr, data: data});
        modelTag = modelTag + 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic freeze, input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 1'b0, 3'd0, 12'h000, freeze, 1'b0);
  endtask

  initial begin
    logic [2:0]  heldAddr;
    logic [11:0] heldData;
    logic [0:0]  heldTag;
    testCount   = 0;
    failCount   = 0;
    modelTag    = 1'b0;
    arst_n      = 1'b0;
    i_req_valid = 1'b0;
    i_req_wen   = 1'b0;
    i_req_addr  = 3'd0;
    i_req_data  = 12'h000;
    i_freeze    = 1'b0;
    i_flush     = 1'b0;
    #12;
    checkOutput("rstValid", 32'(o_valid), 32'd0);
    checkOutput("rstCount", 32'(o_count), 32'd0);
    checkOutput("rstTag", 32'(o_tag), 32'd0);
    checkOutput("rstData", 32'(o_data), 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(1'b0, 1);

    // Fill under freeze, then drain in order.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 3'(i), 12'h0A0 + 12'(i), 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 3'd7, 12'hFFF, 1'b1, 1'b0);
    idle(1'b0, 5);

    // Streaming reads, one per cycle.
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 3'd5, 12'h100 + 12'(i), 1'b0, 1'b0);
    idle(1'b0, 2);

    // Full queue with a request held high while popping.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 3'(i), 12'h200 + 12'(i), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 3'd6, 12'h300 + 12'(i), 1'b0, 1'b0);
    idle(1'b0, 5);

    // Freeze with head = write addr 2, data 0x5A5.
    applyStimulus(1'b1, 1'b1, 3'd2, 12'h5A5, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'd3, 12'h123, 1'b1, 1'b0);
    heldAddr = o_addr;
    heldData = o_data;
    heldTag  = o_tag;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 3'd0, 12'h000, 1'b1, 1'b0);
      checkOutput("frzAddr", 32'(o_addr), 32'd2);
      checkOutput("frzData", 32'(o_data), 32'h5A5);
      checkOutput("frzStable", 32'({heldTag, heldAddr, heldData}), 32'({o_tag, o_addr, o_data}));
    end
    idle(1'b0, 3);

    // Flush with three entries and a live request.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 3'(i + 4), 12'h400 + 12'(i), 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 3'd7, 12'h4FF, 1'b1, 1'b1);
    checkOutput("flushCount", 32'(o_count), 32'd0);
    checkOutput("flushValid", 32'(o_valid), 32'd0);
    applyStimulus(1'b1, 1'b0, 3'd1, 12'h4AA, 1'b0, 1'b0);
    idle(1'b0, 2);

    // Asynchronous reset between edges with two entries queued.
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, 3'(i + 2), 12'h600 + 12'(i), 1'b1, 1'b0);
    i_req_valid = 1'b0;
    #2;
    arst_n = 1'b0;
    #1;
    checkOutput("arstValid", 32'(o_valid), 32'd0);
    checkOutput("arstCount", 32'(o_count), 32'd0);
    checkOutput("arstTag", 32'(o_tag), 32'd0);
    checkOutput("arstReqTag", 32'(o_req_tag), 32'd0);
    sbq.delete();
    modelTag = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b1, 3'd3, 12'h777, 1'b0, 1'b0);
    checkOutput("postRstTag", 32'(o_tag), 32'd0);
    idle(1'b0, 2);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/status_request_queue.md
# status_request_queue

Request buffer that sits directly upstream of the status register file in the instruction cache. It accepts status read and write requests from the cache controller through a valid/ready handshake. It stamps each accepted request with a wrapping tag and holds requests in a small FIFO. It presents the head entry to the status register file, advancing only when that stage is not frozen.

## Interface
- WORD_WIDTH, 12: data word width; must match the status register file.
- ADDR_WIDTH, 3: status register address width.
- TAG_WIDTH, 1: tag width; tags wrap modulo 2^TAG_WIDTH.
- DEPTH_LOG2, 2: FIFO depth is 2^DEPTH_LOG2 entries; minimum 1.

Ports:
- clk  in  1  clock, rising edge.
- arst_n  in  1  reset, asynchronous, active-low.
- i_req_valid  in  1  controller request present.
- i_req_wen  in  1  1 = write, 0 = read.
- i_req_addr  in  ADDR_WIDTH  register address.
- i_req_data  in  WORD_WIDTH  write data; stored but ignored downstream for reads.
- o_req_ready  out  1  queue can accept this cycle.
- o_req_tag  out  TAG_WIDTH  tag that will be assigned if the request is accepted this cycle; equals the tag counter.
- i_flush  in  1  synchronous queue clear.
- i_freeze  in  1  downstream freeze, driven by the status register file's o_freeze_inputs.
- o_tag  out  TAG_WIDTH  head entry tag.
- o_addr  out  ADDR_WIDTH  head entry address.
- o_data  out  WORD_WIDTH  head entry data.
- o_wen  out  1  head entry write flag.
- o_valid  out  1  head entry present.
- o_count  out  DEPTH_LOG2+1  current occupancy.

## Operation
- Storage:
  - 2^DEPTH_LOG2 entries of {tag, wen, addr, data}.
  - Write pointer and read pointer are DEPTH_LOG2 bits each and wrap naturally.
  - Occupancy counter is DEPTH_LOG2+1 bits.
- o_req_ready = (count != 2^DEPTH_LOG2) & ~i_flush. It does not depend on pop in the same cycle, so a full queue refuses even while popping.
- Push = i_req_valid & o_req_ready.
  - On push, the entry is written at the write pointer with tag = tag counter.
  - The write pointer and the tag counter then increment; the tag counter wraps 2^TAG_WIDTH-1 -> 0.
- Head outputs:
  - o_tag, o_addr, o_data and o_wen are driven from the entry at the read pointer; no extra register stage.
  - o_valid = (count != 0).
  - When count == 0, the head fields must still be stable flop values, but their content is don't-care.
- Pop = o_valid & ~i_freeze & ~i_flush. On pop the read pointer increments.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop in the same cycle: unchanged (legal whenever not full).
- Flush (i_flush = 1 at an edge): count <- 0 and read pointer <- write pointer. No push and no pop occur that cycle. The tag counter is NOT reset.
- Freeze holds the head outputs bit-stable for as long as it is asserted. Pushes continue during freeze until the queue is full.
- Reset (arst_n low, any time, including mid-transfer):
  - count, both pointers and the tag counter go to 0.
  - All storage goes to 0, so o_valid=0 and o_tag/o_addr/o_data/o_wen=0.
  - o_req_ready=1 after reset releases, provided i_flush is low.

## Timing
- Latency: a request pushed into an empty queue at edge N appears on o_* immediately after edge N and is consumed by the status register file at edge N+1 if i_freeze is low.
- Throughput: one request per cycle, sustained, with freeze low.
- o_req_ready, o_valid and o_count change only on clk edges or on reset. o_req_ready also drops combinationally with i_flush.
- Handshake: the controller holds its request fields until it sees ready high at a sampling edge. The queue never drops an accepted request except on flush or reset.

## Test plan
- Reset, then push 4 writes (addr 0..3, data 0x0A0..0x0A3) with freeze held high.
  - Required: o_count=4, o_req_ready=0, head is addr 0 with tag 0.
  - Then release freeze: pops on 4 consecutive edges, tags in order 0,1,0,1.
- Streaming with freeze low: push a read at addr 5 every cycle for 10 cycles.
  - Required: o_count stays at 1, o_valid stays high, o_req_tag alternates, and no stall.
- Full plus simultaneous pop: with count=4 and freeze low, hold i_req_valid high.
  - Required: first edge pops only (count 3).
  - Next edge: push+pop, so count stays 3.
- Freeze mid-stream: assert freeze for 3 cycles with head = write addr 2, data 0x5A5.
  - Required: o_addr, o_data and o_tag unchanged across all 3 cycles, and no pop.
- Flush with 3 entries queued while i_req_valid is high.
  - Required: next cycle count=0 and o_valid=0, and the request is not accepted during the flush cycle.
  - The tag counter resumes at its pre-flush value.
- Async reset asserted between edges with 2 entries queued.
  - Required: o_valid=0, o_count=0 and o_tag=0 immediately, without waiting for a clock edge.
  - The first push after release gets tag 0.
